// File: rtl/hash_mode_mux.sv
// hash_mode_mux: selects one of NUM_ENG hash engines and registers its data,
// state and addend buses toward the shared hash datapath. A small controller
// only lets the selected engine change between messages, counts the words of
// the current message and raises a sticky flag on protocol violations.
module hash_mode_mux #(
    parameter int                 DATA_WIDTH   = 32,
    parameter int                 STATE_DWIDTH = 32,
    parameter int                 NUM_ENG      = 2,
    parameter int                 SEL_W        = 1,
    parameter logic [NUM_ENG-1:0] ENG_HAS_E    = 2'b10,
    parameter int                 CNT_W        = 16
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_ENG-1:0]                  EngDataVld,
    input  logic [NUM_ENG*DATA_WIDTH-1:0]       EngDataIn,
    input  logic [NUM_ENG-1:0]                  EngMsgDgstVld,
    input  logic [NUM_ENG*5*STATE_DWIDTH-1:0]   EngState,
    input  logic [NUM_ENG*4*STATE_DWIDTH-1:0]   EngAddend,
    input  logic                                ModeReqVld,
    input  logic [SEL_W-1:0]                    ModeReq,
    output logic                                ModeAck,
    output logic [SEL_W-1:0]                    CurMode,
    output logic                                Busy,
    output logic                                msgDgstVld,
    output logic                                MuxedDataVld,
    output logic [DATA_WIDTH-1:0]               MuxedDataIn,
    output logic [STATE_DWIDTH-1:0]             MuxedStateAComb,
    output logic [STATE_DWIDTH-1:0]             MuxedStateBComb,
    output logic [STATE_DWIDTH-1:0]             MuxedStateCComb,
    output logic [STATE_DWIDTH-1:0]             MuxedStateDComb,
    output logic [STATE_DWIDTH-1:0]             MuxedStateEComb,
    output logic [STATE_DWIDTH-1:0]             MuxedAddend0A,
    output logic [STATE_DWIDTH-1:0]             MuxedAddend0B,
    output logic [STATE_DWIDTH-1:0]             MuxedAddend1A,
    output logic [STATE_DWIDTH-1:0]             MuxedAddend1B,
    output logic [CNT_W-1:0]                    WordCnt,
    output logic                                ProtoErr
);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        DRAIN
    } ctrlState_t;

    ctrlState_t state, stateNext;

    logic [NUM_ENG-1:0]        selMask;
    logic                      selVld;
    logic                      selDgst;
    logic                      selHasE;
    logic [DATA_WIDTH-1:0]     selData;
    logic [5*STATE_DWIDTH-1:0] selState;
    logic [4*STATE_DWIDTH-1:0] selAddend;
    logic                      legalReq;
    logic                      foreignVld;
    logic                      switchWindow;
    logic                      acceptSwitch;
    logic                      badReq;

    // Pick the selected engine's slices and check whether the requested index names a real engine
    always_comb begin
        selMask   = '0;
        selVld    = 1'b0;
        selDgst   = 1'b0;
        selHasE   = 1'b0;
        selData   = '0;
        selState  = '0;
        selAddend = '0;
        legalReq  = 1'b0;
        for (int i = 0; i < NUM_ENG; i++) begin
            if (CurMode == SEL_W'(i)) begin
                selMask[i] = 1'b1;
                selVld     = EngDataVld[i];
                selDgst    = EngMsgDgstVld[i];
                selHasE    = ENG_HAS_E[i];
                selData    = EngDataIn[i*DATA_WIDTH +: DATA_WIDTH];
                selState   = EngState[i*5*STATE_DWIDTH +: 5*STATE_DWIDTH];
                selAddend  = EngAddend[i*4*STATE_DWIDTH +: 4*STATE_DWIDTH];
            end
            if (ModeReq == SEL_W'(i)) begin
                legalReq = 1'b1;
            end
        end
    end

    assign foreignVld   = |((EngDataVld | EngMsgDgstVld) & ~selMask);
    assign switchWindow = (state == IDLE) && !selVld && !selDgst && ModeReqVld;
    assign acceptSwitch = switchWindow && legalReq;
    assign badReq       = switchWindow && !legalReq;
    assign Busy         = (state != IDLE);

    // Message controller next state; a digest always ends the message, even alongside a data word
    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (selDgst) begin
                    stateNext = DRAIN;
                end else if (selVld) begin
                    stateNext = ACTIVE;
                end
            end
            ACTIVE: begin
                if (selDgst) begin
                    stateNext = DRAIN;
                end
            end
            DRAIN: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Controller state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Mode selection, word counting and sticky error; a fresh violation wins over the clear on switch
    always_ff @(posedge clk) begin
        if (rst) begin
            CurMode  <= '0;
            ModeAck  <= 1'b0;
            WordCnt  <= '0;
            ProtoErr <= 1'b0;
        end else begin
            ModeAck <= acceptSwitch;
            if (acceptSwitch) begin
                CurMode <= ModeReq;
            end
            if (acceptSwitch || (state == DRAIN)) begin
                WordCnt <= '0;
            end else if (selVld && (WordCnt != '1)) begin
                WordCnt <= WordCnt + 1'b1;
            end
            if (foreignVld || badReq) begin
                ProtoErr <= 1'b1;
            end else if (acceptSwitch) begin
                ProtoErr <= 1'b0;
            end
        end
    end

    // One-cycle pipeline register toward the datapath; engines without an E register present zero
    always_ff @(posedge clk) begin
        if (rst) begin
            msgDgstVld      <= 1'b0;
            MuxedDataVld    <= 1'b0;
            MuxedDataIn     <= '0;
            MuxedStateAComb <= '0;
            MuxedStateBComb <= '0;
            MuxedStateCComb <= '0;
            MuxedStateDComb <= '0;
            MuxedStateEComb <= '0;
            MuxedAddend0A   <= '0;
            MuxedAddend0B   <= '0;
            MuxedAddend1A   <= '0;
            MuxedAddend1B   <= '0;
        end else begin
            msgDgstVld      <= selDgst;
            MuxedDataVld    <= selVld;
            MuxedDataIn     <= selData;
            MuxedStateAComb <= selState[0*STATE_DWIDTH +: STATE_DWIDTH];
            MuxedStateBComb <= selState[1*STATE_DWIDTH +: STATE_DWIDTH];
            MuxedStateCComb <= selState[2*STATE_DWIDTH +: STATE_DWIDTH];
            MuxedStateDComb <= selState[3*STATE_DWIDTH +: STATE_DWIDTH];
            MuxedStateEComb <= selHasE ? selState[4*STATE_DWIDTH +: STATE_DWIDTH] : '0;
            MuxedAddend0A   <= selAddend[0*STATE_DWIDTH +: STATE_DWIDTH];
            MuxedAddend0B   <= selAddend[1*STATE_DWIDTH +: STATE_DWIDTH];
            MuxedAddend1A   <= selAddend[2*STATE_DWIDTH +: STATE_DWIDTH];
            MuxedAddend1B   <= selAddend[3*STATE_DWIDTH +: STATE_DWIDTH];
        end
    end

endmodule
